// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding a small
// {pc, instr, fault} FIFO towards decode, with redirect flush and drain.
module ifetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    input  logic        redirect,
    output logic        pc_advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          outstanding_q;
    logic [63:0]   tag_q;

    logic [63:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        fault_mem [DEPTH];

    logic        aligned;
    logic        can_issue;
    logic        accepted;
    logic        flush;
    logic        push;
    logic        pop;
    logic [63:0] push_pc;
    logic [31:0] push_instr;
    logic        push_fault;

    assign aligned   = (pc[1:0] == 2'b00);
    assign can_issue = (int'(count_q) + int'(outstanding_q)) < DEPTH;
    assign if_valid  = (count_q != '0);
    assign pop       = if_valid && if_ready;
    assign if_pc     = pc_mem[rd_ptr_q];
    assign if_instr  = instr_mem[rd_ptr_q];
    assign if_fault  = fault_mem[rd_ptr_q];

    assign imem_req_addr = imem_req_valid ? {pc[63:2], 2'b00} : 64'd0;

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        pc_advance     = 1'b0;
        accepted       = 1'b0;
        flush          = 1'b0;
        push           = 1'b0;
        push_pc        = 64'd0;
        push_instr     = 32'd0;
        push_fault     = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (can_issue) begin
                    if (aligned) begin
                        imem_req_valid = 1'b1;
                        if (imem_req_ready) begin
                            accepted   = 1'b1;
                            pc_advance = 1'b1;
                            state_d    = WAIT;
                        end
                    end else begin
                        push       = 1'b1;
                        push_pc    = pc;
                        push_instr = NOP_INSTR;
                        push_fault = 1'b1;
                        pc_advance = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    push       = 1'b1;
                    push_pc    = tag_q;
                    push_instr = imem_resp_data;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A response landing in the redirect cycle settles the old request,
        // so only a still-unanswered request sends us to DRAIN.
        if (redirect && (state_q != IDLE)) begin
            flush      = 1'b1;
            push       = 1'b0;
            pc_advance = 1'b0;
            if (accepted
                || ((state_q == WAIT) && !imem_resp_valid)
                || ((state_q == DRAIN) && !imem_resp_valid)) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end

        if (reset) begin
            imem_req_valid = 1'b0;
            pc_advance     = 1'b0;
            accepted       = 1'b0;
            flush          = 1'b0;
            push           = 1'b0;
            state_d        = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            outstanding_q <= 1'b0;
            tag_q         <= 64'd0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= (state_d == WAIT) || (state_d == DRAIN);
            if (accepted) begin
                tag_q <= pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= 64'd0;
                instr_mem[i] <= 32'd0;
                fault_mem[i] <= 1'b0;
            end
        end else if (flush) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr_q]    <= push_pc;
                instr_mem[wr_ptr_q] <= push_instr;
                fault_mem[wr_ptr_q] <= push_fault;
                wr_ptr_q            <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: PC and imem models in one thread, scoreboard of
// expected decode entries, hand sequences for stall/redirect/reset, vector table.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        redirect;
    logic        pc_advance;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(2), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .redirect        (redirect),
        .pc_advance      (pc_advance),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_fault        (if_fault)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    typedef struct {
        logic [63:0] pc;
        int          lat;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    entry_t      sbq[$];
    vec_t        vecs[6];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] tgt;
    int          lat;
    bit          pend;
    int          cnt;
    logic [63:0] paddr;

    logic        s_adv;
    logic        s_rv;
    logic [63:0] s_addr;
    logic        s_ifv;
    logic [63:0] s_ifpc;
    logic [31:0] s_ifi;
    logic        s_iff;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'h0050_0093;
        return 32'hA5A5_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick();
        entry_t      e;
        logic [63:0] npc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        if (pend) begin
            if (cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
        s_adv  = pc_advance;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_ifv  = if_valid;
        s_ifpc = if_pc;
        s_ifi  = if_instr;
        s_iff  = if_fault;
        if (reset) begin
            sbq.delete();
            pend = 1'b0;
        end else begin
            if (s_ifv && if_ready) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h expected no entry", s_ifpc);
                end else begin
                    e = sbq.pop_front();
                    check("sb_pc", s_ifpc, e.pc);
                    check("sb_instr", 64'(s_ifi), 64'(e.instr));
                    check("sb_fault", 64'(s_iff), 64'(e.fault));
                end
            end
            if (s_rv) begin
                check("req_addr", s_addr, {pc[63:2], 2'b00});
                check("req_aligned", 64'(pc[1:0]), 64'd0);
            end
            if (redirect) begin
                check("adv_on_redirect", 64'(s_adv), 64'd0);
            end else begin
                if (s_rv && imem_req_ready) begin
                    e.pc = pc; e.instr = mem_word(pc); e.fault = 1'b0;
                    sbq.push_back(e);
                end
                if (s_adv && (pc[1:0] != 2'b00)) begin
                    e.pc = pc; e.instr = NOP; e.fault = 1'b1;
                    sbq.push_back(e);
                end
            end
            if (s_rv && imem_req_ready) begin
                pend  = 1'b1;
                cnt   = lat - 1;
                paddr = pc;
            end
            if (redirect) sbq.delete();
        end
        if (reset) npc = 64'd0;
        else if (redirect) npc = tgt;
        else if (s_adv) npc = pc + 64'd4;
        else npc = pc;
        @(posedge clk);
        @(negedge clk);
        pc       = npc;
        redirect = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vecs[0] = '{pc: 64'h100,  lat: 1, instr: 32'hA5A5_0100, fault: 1'b0};
        vecs[1] = '{pc: 64'h2000, lat: 3, instr: 32'hA5A5_2000, fault: 1'b0};
        vecs[2] = '{pc: 64'h1002, lat: 1, instr: NOP,           fault: 1'b1};
        vecs[3] = '{pc: 64'h0,    lat: 2, instr: 32'h0050_0093, fault: 1'b0};
        vecs[4] = '{pc: 64'hFFFF_FFFF_FFFF_FFFC, lat: 1,
                    instr: 32'hA5A5_FFFC, fault: 1'b0};
        vecs[5] = '{pc: 64'h31,   lat: 1, instr: NOP,           fault: 1'b1};

        reset = 1'b1; pc = 64'd0; redirect = 1'b0; tgt = 64'd0;
        imem_req_ready = 1'b1; if_ready = 1'b0; lat = 1; pend = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        @(negedge clk);
        tick();
        tick();
        check("rst_if_valid", 64'(s_ifv), 64'd0);
        check("rst_req_valid", 64'(s_rv), 64'd0);
        check("rst_pc_advance", 64'(s_adv), 64'd0);
        check("rst_if_pc", s_ifpc, 64'd0);
        check("rst_if_instr", 64'(s_ifi), 64'd0);
        check("rst_if_fault", 64'(s_iff), 64'd0);

        // basic fetch, 1-cycle memory
        reset = 1'b0;
        tick();
        check("t1_idle_req", 64'(s_rv), 64'd0);
        check("t1_idle_adv", 64'(s_adv), 64'd0);
        tick();
        check("t1_req_valid", 64'(s_rv), 64'd1);
        check("t1_req_addr", s_addr, 64'd0);
        check("t1_adv", 64'(s_adv), 64'd1);
        tick();
        check("t1_wait_req", 64'(s_rv), 64'd0);
        check("t1_wait_ifv", 64'(s_ifv), 64'd0);
        tick();
        check("t1_ifv", 64'(s_ifv), 64'd1);
        check("t1_if_pc", s_ifpc, 64'd0);
        check("t1_if_instr", 64'(s_ifi), 64'h0050_0093);
        check("t1_if_fault", 64'(s_iff), 64'd0);
        check("t2_second_req", s_addr, 64'd4);

        // FIFO full with decode stalled
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_full_req", 64'(s_rv), 64'd0);
            check("t2_full_adv", 64'(s_adv), 64'd0);
            check("t2_head_pc", s_ifpc, 64'd0);
        end
        if_ready = 1'b1;
        tick();
        check("t2_pop_req", 64'(s_rv), 64'd0);
        if_ready = 1'b0;
        tick();
        check("t2_third_req", 64'(s_rv), 64'd1);
        check("t2_third_addr", s_addr, 64'd8);
        check("t2_third_adv", 64'(s_adv), 64'd1);

        // request held stable while memory is not ready
        if_ready = 1'b1;
        imem_req_ready = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                seen = s_rv;
            end
            if (!seen) timeout("stall_req_seen");
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_req_valid", 64'(s_rv), 64'd1);
            check("stall_adv", 64'(s_adv), 64'd0);
        end

        // misaligned pc produces a fault entry
        redirect = 1'b1; tgt = 64'h6;
        tick();
        imem_req_ready = 1'b1;
        tick();
        check("t3_no_req", 64'(s_rv), 64'd0);
        check("t3_adv", 64'(s_adv), 64'd1);
        tick();
        check("t3_ifv", 64'(s_ifv), 64'd1);
        check("t3_if_pc", s_ifpc, 64'h6);
        check("t3_if_instr", 64'(s_ifi), 64'(NOP));
        check("t3_if_fault", 64'(s_iff), 64'd1);

        // redirect while waiting on a 3-cycle response
        lat = 3; redirect = 1'b1; tgt = 64'h100;
        tick();
        tick();
        check("t4_req", 64'(s_rv), 64'd1);
        check("t4_req_addr", s_addr, 64'h100);
        redirect = 1'b1; tgt = 64'h200;
        tick();
        check("t4_redir_req", 64'(s_rv), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t4_drain_req", 64'(s_rv), 64'd0);
            check("t4_drain_ifv", 64'(s_ifv), 64'd0);
        end
        lat = 2;
        tick();
        check("t4_new_req", 64'(s_rv), 64'd1);
        check("t4_new_addr", s_addr, 64'h200);
        check("t4_new_ifv", 64'(s_ifv), 64'd0);

        // redirect in the same cycle as a request handshake
        tick();
        tick();
        redirect = 1'b1; tgt = 64'h400;
        tick();
        check("t5_hs_req", 64'(s_rv), 64'd1);
        check("t5_hs_addr", s_addr, 64'h204);
        check("t5_hs_ifv", 64'(s_ifv), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t5_drain_req", 64'(s_rv), 64'd0);
            check("t5_drain_ifv", 64'(s_ifv), 64'd0);
        end
        tick();
        check("t5_new_req", 64'(s_rv), 64'd1);
        check("t5_new_addr", s_addr, 64'h400);
        check("t5_new_ifv", 64'(s_ifv), 64'd0);

        // reset with an entry buffered and a request outstanding
        if_ready = 1'b0; lat = 3;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 30 && !hit; i++) begin
                tick();
                hit = s_ifv && pend;
            end
            if (!hit) timeout("t6_setup");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t6_ifv", 64'(s_ifv), 64'd0);
        check("t6_req", 64'(s_rv), 64'd0);
        check("t6_adv", 64'(s_adv), 64'd0);
        tick();
        check("t6_resume_req", 64'(s_rv), 64'd1);
        check("t6_resume_addr", s_addr, 64'd0);
        if_ready = 1'b1; lat = 1;
        run(6);

        // vector table: redirect to pc, expect that entry first at decode
        for (int v = 0; v < 6; v++) begin
            bit got = 1'b0;
            redirect = 1'b1; tgt = vecs[v].pc; lat = vecs[v].lat;
            tick();
            for (int i = 0; i < 40 && !got; i++) begin
                tick();
                if (s_ifv) begin
                    got = 1'b1;
                    check("vec_pc", s_ifpc, vecs[v].pc);
                    check("vec_instr", 64'(s_ifi), 64'(vecs[v].instr));
                    check("vec_fault", 64'(s_iff), 64'(vecs[v].fault));
                end
            end
            if (!got) timeout("vec_entry");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
